apmu_pmc_bank: RTL

Counter-side slave of the APMU performance-counter interface: a bank of `NUM_COUNTERS` 32-bit event counters with per-counter event selects and sticky overflow flags. It sits directly downstream of the core's PMU counter stage and serves its three operations: `PMC_REQ`, `PMC_WFP` and `PMC_WFO`. `PMC_REQ` is a single read or write. `PMC_WFP` (wait-for-positive) and `PMC_WFO` (wait-for-overflow) are blocking waits, and the response carries the counter value.

---
 rtl/apmu_ibex_pkg.sv | 7 +
 rtl/apmu_pmc_counter.sv | 47 ++++
 rtl/apmu_pmc_bank.sv | 129 ++++++++++++
 3 files changed

// File: rtl/apmu_ibex_pkg.sv
// apmu_ibex_pkg: shared types for the APMU performance-counter bank.
package apmu_ibex_pkg;
    typedef enum logic [1:0] {PMC_IDLE, PMC_REQ, PMC_WFP, PMC_WFO} pmc_op_e;
    typedef enum logic [1:0] {CNT, EVSEL, STATUS, RSVD} pmc_region_e;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} pmc_bank_fsm_e;
    localparam int PMC_MAX_COUNTERS = 16;
endpackage

// File: rtl/apmu_pmc_counter.sv
// apmu_pmc_counter: one 32-bit event counter with its event select and sticky overflow flag.
module apmu_pmc_counter
    import apmu_ibex_pkg::*;
#(
    parameter int NUM_EVENTS = 16,
    localparam int EW = $clog2(NUM_EVENTS)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [NUM_EVENTS-1:0] event_i,
    input  logic                  cnt_we_i,
    input  logic                  sel_we_i,
    input  logic                  flag_clr_i,
    input  logic [31:0]           wdata_i,
    output logic [31:0]           cnt_o,
    output logic [EW-1:0]         sel_o,
    output logic                  flag_o
);
    logic [31:0] cnt_q, cnt_d;
    logic [EW-1:0] sel_q, sel_d;
    logic flag_q, flag_d, inc, wrap;

    always_comb begin
        inc = 32'(sel_q) < NUM_EVENTS ? event_i[sel_q] : 1'b0;
        wrap = inc && !cnt_we_i && &cnt_q;
        cnt_d = cnt_we_i ? wdata_i : cnt_q + 32'(inc);
        sel_d = sel_we_i ? wdata_i[EW-1:0] : sel_q;
        // a fresh wrap outranks any clear; a counter write outranks everything
        flag_d = !cnt_we_i && (wrap || (flag_q && !flag_clr_i));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            sel_q <= '0;
            flag_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sel_q <= sel_d;
            flag_q <= flag_d;
        end
    end

    assign cnt_o = cnt_q;
    assign sel_o = sel_q;
    assign flag_o = flag_q;
endmodule

// File: rtl/apmu_pmc_bank.sv
// apmu_pmc_bank: APMU counter bank serving PMC_REQ/WFP/WFO requests.
// Optional overflow interrupt output enabled by APMU_PMC_OVF_IRQ_EN.
module apmu_pmc_bank
    import apmu_ibex_pkg::*;
#(
    parameter int          NUM_COUNTERS = 8,
    parameter int          NUM_EVENTS   = 16,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  pmc_op_e               counter_op_i,
    output logic                  counter_gnt_o,
    output logic                  counter_rvalid_o,
    output logic                  counter_err_o,
    input  logic [31:0]           counter_addr_i,
    input  logic                  counter_we_i,
    input  logic [31:0]           counter_wdata_i,
    output logic [31:0]           counter_rdata_o,
    input  logic [NUM_EVENTS-1:0] event_i
`ifdef APMU_PMC_OVF_IRQ_EN
    ,
    output logic                  ovf_irq_o
`endif
);
    localparam int EW = $clog2(NUM_EVENTS);

    pmc_bank_fsm_e state_q, state_d;
    pmc_op_e op_q, op_d;
    pmc_region_e region;
    logic [3:0] idx, widx_q, widx_d;
    logic [31:0] rdata_q, rdata_d, rd_val, wcnt;
    logic err_q, err_d;
    logic dec_err, accept, resp_now, wr, wait_cond, wait_hit;
    logic [31:0] cnt [PMC_MAX_COUNTERS];
    logic [EW-1:0] sel [PMC_MAX_COUNTERS];
    logic [PMC_MAX_COUNTERS-1:0] flags;

    assign region = pmc_region_e'(counter_addr_i[7:6]);
    assign idx = counter_addr_i[5:2];

    always_comb begin
        dec_err = counter_addr_i[31:8] != BASE_ADDR[31:8] || counter_addr_i[1:0] != 2'b0
            || 32'(idx) >= NUM_COUNTERS || region == RSVD || (region == STATUS && idx != 4'd0)
            || (counter_op_i != PMC_REQ && region != CNT);
        accept = state_q == IDLE && counter_op_i != PMC_IDLE;
        resp_now = accept && (counter_op_i == PMC_REQ || dec_err);
        wr = accept && counter_op_i == PMC_REQ && counter_we_i && !dec_err;
        rd_val = region == CNT ? cnt[idx] : region == EVSEL ? 32'(sel[idx]) : 32'(flags);
        wcnt = cnt[widx_q];
        wait_cond = op_q == PMC_WFP ? !wcnt[31] && wcnt != 32'h0 : flags[widx_q];
        wait_hit = state_q == WAIT && counter_op_i != PMC_IDLE && wait_cond;
    end

    // slots beyond NUM_COUNTERS read as zero so the decode can index a fixed-size array
    for (genvar g = 0; g < PMC_MAX_COUNTERS; g++) begin : g_cnt
        if (g < NUM_COUNTERS) begin : g_on
            apmu_pmc_counter #(.NUM_EVENTS(NUM_EVENTS)) u_cnt (
                .clk_i      (clk_i),
                .rst_ni     (rst_ni),
                .event_i    (event_i),
                .cnt_we_i   (wr && region == CNT && 32'(idx) == g),
                .sel_we_i   (wr && region == EVSEL && 32'(idx) == g),
                .flag_clr_i ((wr && region == STATUS && counter_wdata_i[g])
                             || (wait_hit && op_q == PMC_WFO && 32'(widx_q) == g)),
                .wdata_i    (counter_wdata_i),
                .cnt_o      (cnt[g]),
                .sel_o      (sel[g]),
                .flag_o     (flags[g])
            );
        end else begin : g_off
            assign cnt[g] = '0;
            assign sel[g] = '0;
            assign flags[g] = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: state_d = !accept ? IDLE : resp_now ? RESP : WAIT;
            WAIT: state_d = counter_op_i == PMC_IDLE ? IDLE : wait_cond ? RESP : WAIT;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        counter_gnt_o = state_q == IDLE;
        counter_rvalid_o = state_q == RESP;
    end

    always_comb begin
        op_d = accept ? counter_op_i : op_q;
        widx_d = accept ? idx : widx_q;
        rdata_d = resp_now ? (dec_err ? 32'h0 : rd_val) : wait_hit ? wcnt : rdata_q;
        err_d = resp_now ? dec_err : wait_hit ? 1'b0 : err_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            op_q <= PMC_IDLE;
            widx_q <= '0;
            rdata_q <= '0;
            err_q <= 1'b0;
        end else begin
            op_q <= op_d;
            widx_q <= widx_d;
            rdata_q <= rdata_d;
            err_q <= err_d;
        end
    end

    assign counter_rdata_o = rdata_q;
    assign counter_err_o = err_q;

`ifdef APMU_PMC_OVF_IRQ_EN
    logic irq_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) irq_q <= 1'b0;
        else irq_q <= |flags;
    end
    assign ovf_irq_o = irq_q;
`endif
endmodule
